// File: rtl/pipeline_debug_ctrl.sv
// Host debug controller: loads a program into the MIPS pipeline over UART,
// runs it continuously or single-step, and streams write-back results back.
`timescale 1ns/1ps
module pipeline_debug_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_STEP  = 4,
    parameter logic [7:0]  CMD_LOAD   = 8'h4C,
    parameter logic [7:0]  CMD_CONT   = 8'h43,
    parameter logic [7:0]  CMD_STEP   = 8'h53,
    parameter logic [7:0]  CMD_NEXT   = 8'h4E
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_start,
    output logic                  o_step,
    input  logic                  i_finish,
    input  logic [DATA_WIDTH-1:0] i_result_wb,
    output logic                  o_busy
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_LOAD_CNT    = 4'd1;
    localparam logic [3:0] S_LOAD_BYTE   = 4'd2;
    localparam logic [3:0] S_LOAD_WRITE  = 4'd3;
    localparam logic [3:0] S_RUN         = 4'd4;
    localparam logic [3:0] S_STEP_WAIT   = 4'd5;
    localparam logic [3:0] S_STEP_PULSE  = 4'd6;
    localparam logic [3:0] S_STEP_SAMPLE = 4'd7;
    localparam logic [3:0] S_SEND        = 4'd8;
    localparam logic [3:0] S_DONE        = 4'd9;

    logic [3:0]            r_state,    w_state;
    logic [7:0]            r_rem,      w_rem;
    logic [BCW-1:0]        r_bcnt,     w_bcnt;
    logic [DATA_WIDTH-1:0] r_instr,    w_instr;
    logic [DATA_WIDTH-1:0] r_addr,     w_addr;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift;
    logic                  r_ret_done, w_ret_done;
    logic                  r_loading,  w_loading;
    logic                  r_start,    w_start;
    logic                  r_step,     w_step;
    logic [7:0]            r_tx_data,  w_tx_data;
    logic                  r_tx_valid, w_tx_valid;
    logic                  r_busy,     w_busy;

    // State and registered outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_bcnt     <= '0;
            r_instr    <= '0;
            r_addr     <= '0;
            r_shift    <= '0;
            r_ret_done <= 1'b0;
            r_loading  <= 1'b0;
            r_start    <= 1'b0;
            r_step     <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_rem      <= w_rem;
            r_bcnt     <= w_bcnt;
            r_instr    <= w_instr;
            r_addr     <= w_addr;
            r_shift    <= w_shift;
            r_ret_done <= w_ret_done;
            r_loading  <= w_loading;
            r_start    <= w_start;
            r_step     <= w_step;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_busy     <= w_busy;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state    = r_state;
        w_rem      = r_rem;
        w_bcnt     = r_bcnt;
        w_instr    = r_instr;
        w_addr     = r_addr;
        w_shift    = r_shift;
        w_ret_done = r_ret_done;
        w_loading  = 1'b0;
        w_start    = r_start;
        w_step     = 1'b0;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;

        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        w_state = S_LOAD_CNT;
                    end else if (i_rx_data == CMD_CONT) begin
                        w_state = S_RUN;
                        w_start = 1'b1;
                    end else if (i_rx_data == CMD_STEP) begin
                        w_state = S_STEP_WAIT;
                    end
                end
            end
            S_LOAD_CNT: begin
                if (i_rx_valid) begin
                    w_rem   = i_rx_data;
                    w_addr  = '0;
                    w_bcnt  = '0;
                    w_state = (i_rx_data == 8'd0) ? S_IDLE : S_LOAD_BYTE;
                end
            end
            S_LOAD_BYTE: begin
                if (i_rx_valid) begin
                    w_instr = {r_instr[DATA_WIDTH-9:0], i_rx_data};
                    if (r_bcnt == BCW'(NBYTES - 1)) begin
                        w_bcnt    = '0;
                        w_loading = 1'b1;
                        w_state   = S_LOAD_WRITE;
                    end else begin
                        w_bcnt = r_bcnt + BCW'(1);
                    end
                end
            end
            S_LOAD_WRITE: begin
                w_addr  = r_addr + DATA_WIDTH'(ADDR_STEP);
                w_rem   = r_rem - 8'd1;
                w_state = (r_rem == 8'd1) ? S_IDLE : S_LOAD_BYTE;
            end
            S_RUN: begin
                if (i_finish) begin
                    w_start    = 1'b0;
                    w_shift    = i_result_wb;
                    w_tx_data  = i_result_wb[DATA_WIDTH-1 -: 8];
                    w_tx_valid = 1'b1;
                    w_bcnt     = '0;
                    w_ret_done = 1'b1;
                    w_state    = S_SEND;
                end
            end
            S_STEP_WAIT: begin
                if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
                    w_step  = 1'b1;
                    w_state = S_STEP_PULSE;
                end
            end
            S_STEP_PULSE: begin
                w_state = S_STEP_SAMPLE;
            end
            S_STEP_SAMPLE: begin
                w_shift    = i_result_wb;
                w_tx_data  = i_result_wb[DATA_WIDTH-1 -: 8];
                w_tx_valid = 1'b1;
                w_bcnt     = '0;
                w_ret_done = i_finish;
                w_state    = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    if (r_bcnt == BCW'(NBYTES - 1)) begin
                        w_tx_valid = 1'b0;
                        w_bcnt     = '0;
                        w_state    = r_ret_done ? S_DONE : S_STEP_WAIT;
                    end else begin
                        w_bcnt    = r_bcnt + BCW'(1);
                        w_shift   = r_shift << 8;
                        w_tx_data = r_shift[DATA_WIDTH-9 -: 8];
                    end
                end
            end
            S_DONE: begin
                // Halt marker goes out after the gap cycle that follows the result
                if (!r_tx_valid) begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = 8'hFF;
                end else if (i_tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_state    = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_instruccion = r_instr;
    assign o_address     = r_addr;
    assign o_loading     = r_loading;
    assign o_start       = r_start;
    assign o_step        = r_step;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Randomized self-checking bench for pipeline_debug_ctrl.
`timescale 1ns/1ps
module tb_pipeline_debug_ctrl;

    localparam int unsigned DW = 32;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b0;
    logic [7:0]    i_rx_data = 8'd0;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready = 1'b0;
    logic [DW-1:0] o_instruccion;
    logic [DW-1:0] o_address;
    logic          o_loading;
    logic          o_start;
    logic          o_step;
    logic          i_finish = 1'b0;
    logic [DW-1:0] i_result_wb = '0;
    logic          o_busy;

    pipeline_debug_ctrl dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_instruccion(o_instruccion),
        .o_address    (o_address),
        .o_loading    (o_loading),
        .o_start      (o_start),
        .o_step       (o_step),
        .i_finish     (i_finish),
        .i_result_wb  (i_result_wb),
        .o_busy       (o_busy)
    );

    always #5 i_clock = ~i_clock;

    int         tests = 0;
    int         fails = 0;
    int         step_cnt = 0;
    int         load_cnt = 0;
    int         rdy_mode = 0;
    logic [7:0] tx_q[$];

    logic [76:0] all_o;
    assign all_o = {o_tx_data, o_tx_valid, o_instruccion, o_address,
                    o_loading, o_start, o_step, o_busy};

    // Transmitter model: ready pattern selected by rdy_mode
    initial begin : ready_drv
        int ph;
        ph = 0;
        forever begin
            @(negedge i_clock);
            ph++;
            case (rdy_mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = ((ph % 3) == 0);
                default: i_tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observer: collects accepted tx bytes, counts pulses, checks hold and exclusivity
    initial begin : monitor
        logic       pv, pa;
        logic [7:0] pd;
        pv = 1'b0; pa = 1'b0; pd = 8'd0;
        forever begin
            @(negedge i_clock);
            #1;
            if (i_reset) begin
                if (pv && !pa) begin
                    tests++;
                    if (o_tx_valid !== 1'b1 || o_tx_data !== pd) begin
                        fails++;
                        $display("FAIL tx_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                                 o_tx_valid, o_tx_data, pd);
                    end
                end
                if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
                if (o_step) begin
                    step_cnt++;
                    tests++;
                    if (o_loading !== 1'b0 || o_start !== 1'b0) begin
                        fails++;
                        $display("FAIL step_exclusive: loading=%0b start=%0b, required 0/0",
                                 o_loading, o_start);
                    end
                end
                if (o_loading) load_cnt++;
            end
            pv = o_tx_valid && i_reset;
            pa = o_tx_valid && i_tx_ready;
            pd = o_tx_data;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clock);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clock);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        int c;
        c = 0;
        while (tx_q.size() < n && c < 300) begin
            @(negedge i_clock);
            #2;
            c++;
        end
        if (tx_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d tx bytes, required %0d", name, tx_q.size(), n);
        end
    endtask

    task automatic run_load(input logic [7:0] d[$], input bit rnd_gap, input string name);
        int          n;
        int          l0;
        logic [31:0] exp_w;
        n  = d.size() / 4;
        l0 = load_cnt;
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (rnd_gap) idle($urandom_range(0, 2));
                send_byte(d[4*k+j]);
            end
            exp_w = {d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]};
            tests++;
            if (o_loading !== 1'b1 || o_instruccion !== exp_w || o_address !== 32'(4*k)) begin
                fails++;
                $display("FAIL %s_word%0d: loading=%0b instr=%08h addr=%08h, required 1 %08h %08h",
                         name, k, o_loading, o_instruccion, o_address, exp_w, 32'(4*k));
            end
        end
        idle(1);
        tests++;
        if (o_busy !== 1'b0 || (load_cnt - l0) != n) begin
            fails++;
            $display("FAIL %s_end: busy=%0b writes=%0d, required busy=0 writes=%0d",
                     name, o_busy, load_cnt - l0, n);
        end
    endtask

    task automatic check_tx(input logic [31:0] val, input bit with_ff, input string name);
        int         n;
        logic [7:0] exp_b;
        n = with_ff ? 5 : 4;
        wait_tx(n, name);
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            exp_b = (i == 4) ? 8'hFF : 8'(val >> (8 * (3 - i)));
            tests++;
            if (tx_q[i] !== exp_b) begin
                fails++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, tx_q[i], exp_b);
            end
        end
        idle(3);
        tests++;
        if (tx_q.size() != n) begin
            fails++;
            $display("FAIL %s_count: got %0d tx bytes, required %0d", name, tx_q.size(), n);
        end
        tx_q.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        idle(3);
        tests++;
        if (all_o !== 77'd0) begin
            fails++;
            $display("FAIL reset_init: outputs=%h, required 0", all_o);
        end
        i_reset = 1'b1;
        send_byte(8'h4C);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tests++;
        if (o_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_midload_busy: busy=%0b, required 1", o_busy);
        end
        #2;
        i_reset = 1'b0;
        #1;
        tests++;
        if (all_o !== 77'd0) begin
            fails++;
            $display("FAIL reset_async: outputs=%h, required 0", all_o);
        end
        idle(1);
        i_reset = 1'b1;
        send_byte(8'h43);
        tests++;
        if (o_start !== 1'b1 || o_busy !== 1'b1 || o_address !== '0) begin
            fails++;
            $display("FAIL reset_then_run: start=%0b busy=%0b addr=%08h, required 1 1 0",
                     o_start, o_busy, o_address);
        end
        i_result_wb = 32'hCAFE0001;
        i_finish    = 1'b1;
        idle(1);
        i_finish    = 1'b0;
        check_tx(32'hCAFE0001, 1'b1, "reset_run");
    endtask

    task automatic test_load();
        logic [7:0] d[$];
        d = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
        run_load(d, 1'b0, "load_fixed");
        for (int r = 0; r < 3; r++) begin
            d.delete();
            for (int i = 0; i < 4 * $urandom_range(1, 4); i++) d.push_back(8'($urandom));
            run_load(d, 1'b1, "load_rand");
        end
    endtask

    task automatic test_load_zero();
        int l0;
        l0 = load_cnt;
        send_byte(8'h4C);
        tests++;
        if (o_busy !== 1'b1) begin
            fails++;
            $display("FAIL load0_busy: busy=%0b, required 1", o_busy);
        end
        send_byte(8'h00);
        idle(2);
        tests++;
        if (o_busy !== 1'b0 || load_cnt != l0) begin
            fails++;
            $display("FAIL load0_end: busy=%0b writes=%0d, required 0 0", o_busy, load_cnt - l0);
        end
    endtask

    task automatic test_continuous(input int k, input logic [31:0] val, input int mode);
        int cnt;
        rdy_mode    = mode;
        i_result_wb = val;
        send_byte(8'h43);
        cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            if (o_start) cnt++;
            else break;
            if (cnt == k) i_finish = 1'b1;
            @(negedge i_clock);
            i_finish = 1'b0;
        end
        tests++;
        if (cnt != k) begin
            fails++;
            $display("FAIL cont_start_len: start high %0d cycles, required %0d", cnt, k);
        end
        check_tx(val, 1'b1, "cont");
        tests++;
        if (o_busy !== 1'b0 || o_start !== 1'b0) begin
            fails++;
            $display("FAIL cont_end: busy=%0b start=%0b, required 0 0", o_busy, o_start);
        end
    endtask

    task automatic test_step();
        int          s0;
        logic [31:0] v;
        rdy_mode = 1;
        send_byte(8'h53);
        s0 = step_cnt;
        send_byte(8'h00);
        idle(2);
        tests++;
        if (o_busy !== 1'b1 || o_start !== 1'b0 || step_cnt != s0) begin
            fails++;
            $display("FAIL step_garbage: busy=%0b start=%0b steps=%0d, required 1 0 0",
                     o_busy, o_start, step_cnt - s0);
        end
        for (int r = 0; r < 3; r++) begin
            v           = (r == 0) ? 32'h12345678 : 32'($urandom);
            i_result_wb = v;
            i_finish    = 1'b0;
            if (r > 0) rdy_mode = 2;
            s0 = step_cnt;
            send_byte(8'h4E);
            check_tx(v, 1'b0, "step");
            tests++;
            if (step_cnt - s0 != 1 || o_busy !== 1'b1) begin
                fails++;
                $display("FAIL step_pulse: steps=%0d busy=%0b, required 1 1", step_cnt - s0, o_busy);
            end
        end
    endtask

    task automatic test_step_halt();
        logic [31:0] v;
        v           = 32'($urandom);
        rdy_mode    = 1;
        i_result_wb = v;
        i_finish    = 1'b1;
        send_byte(8'h4E);
        wait_tx(1, "halt_first");
        send_byte(8'h4C);
        check_tx(v, 1'b1, "halt");
        i_finish = 1'b0;
        idle(2);
        tests++;
        if (o_busy !== 1'b0 || o_start !== 1'b0 || o_tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_end: busy=%0b start=%0b txv=%0b, required 0 0 0",
                     o_busy, o_start, o_tx_valid);
        end
    endtask

    initial begin : main
        test_reset();
        test_load();
        test_load_zero();
        test_continuous(50, 32'h0000000A, 0);
        test_continuous(int'($urandom_range(1, 20)), 32'($urandom), 2);
        test_step();
        test_step_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
- Sits between the UART byte receiver/transmitter and the MIPS pipeline top-level.
- Loads the program into instruction memory through the pipeline's loading/instruction/address inputs.
- Runs the program in either continuous or single-step mode through the pipeline's start/step inputs.
- After every step, and at halt, streams the 32-bit write-back result back to the host.

Parameters:
DATA_WIDTH, 32, width of instruction, address and result words
ADDR_STEP, 4, byte increment of o_address per loaded instruction
CMD_LOAD, 8'h4C, host command byte: load program
CMD_CONT, 8'h43, host command byte: continuous run
CMD_STEP, 8'h53, host command byte: enter step mode
CMD_NEXT, 8'h4E, host byte in step mode: advance one cycle

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  tx request, held until accepted
i_tx_ready  in  1  transmitter accepts o_tx_data when high with o_tx_valid
o_instruccion  out  DATA_WIDTH  assembled instruction word
o_address  out  DATA_WIDTH  instruction memory byte address
o_loading  out  1  one-cycle write strobe for o_instruccion/o_address
o_start  out  1  continuous-run enable to pipeline
o_step  out  1  one-cycle single-step pulse to pipeline
i_finish  in  1  halt reached write-back (pipeline o_finish)
i_result_wb  in  DATA_WIDTH  write-back data from pipeline
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_reset low, asynchronous): state IDLE; all outputs 0; counters 0; o_address 0.
- IDLE:
  - On i_rx_valid, decode the byte.
  - CMD_LOAD -> LOAD_CNT.
  - CMD_CONT -> RUN.
  - CMD_STEP -> STEP_WAIT.
  - Any other byte: ignored.
- LOAD_CNT:
  - Next rx byte = instruction count N.
  - Clear o_address to 0 and the byte counter.
  - N==0 -> IDLE, nothing written.
  - Otherwise -> LOAD_BYTE.
- LOAD_BYTE:
  - Each rx byte is shifted into o_instruccion MSB-first (first byte lands in [31:24]).
  - After the 4th byte -> LOAD_WRITE.
- LOAD_WRITE (1 cycle):
  - o_loading=1 with the final o_instruccion/o_address.
  - Next cycle: o_address += ADDR_STEP and remaining count decrements.
  - Remaining==0 -> IDLE, else -> LOAD_BYTE.
  - A byte from a 4-byte group is never written partially.
- Latency: o_loading asserts exactly 1 cycle after the 4th byte's i_rx_valid.
- RUN:
  - o_start=1 continuously.
  - On i_finish: o_start drops the next cycle; capture i_result_wb; -> SEND with return target DONE.
- STEP_WAIT:
  - o_start=0.
  - On rx CMD_NEXT -> STEP_PULSE.
  - Any other byte is ignored.
- STEP_PULSE (1 cycle):
  - o_step=1 for exactly one cycle.
  - Then -> STEP_SAMPLE.
- STEP_SAMPLE (1 cycle):
  - Capture i_result_wb and i_finish.
  - -> SEND; return target DONE if i_finish was 1, else STEP_WAIT.
- SEND:
  - Transmit the captured word, 4 bytes, MSB first.
  - Each byte is presented with o_tx_valid=1 and held stable until i_tx_ready.
  - After the 4th handshake, go to the return target.
  - o_tx_valid drops in the cycle after the last accept.
- DONE:
  - Transmit one byte 8'hFF via the same handshake, then -> IDLE.
  - o_start and o_step remain 0.
- Rx bytes arriving in RUN, STEP_PULSE, STEP_SAMPLE, SEND or DONE are dropped. There is no rx buffering.
- i_finish in IDLE, LOAD_* or STEP_WAIT is ignored.
- o_step and o_loading are never high simultaneously. o_start and o_step are never high simultaneously.
- Reset mid-operation (load, run or send) aborts immediately to IDLE with all outputs 0. A partially transmitted word is not resumed.
- o_busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: hold i_reset=0 mid-LOAD_BYTE -> all outputs 0, o_address 0, next byte 8'h43 enters RUN.
- Load: rx 4C,02,20,01,00,05,FC,00,00,00 -> o_loading pulses twice: (0x20010005 @0x0), then (0xFC000000 @0x4). Each pulse comes 1 cycle after its 4th byte. Ends in IDLE.
- Load N=0: rx 4C,00 -> no o_loading; back to IDLE; o_busy low one cycle later.
- Continuous: rx 43, i_finish after 50 cycles with i_result_wb=0x0000000A -> o_start high 50 cycles then low. TX bytes 00,00,00,0A,FF in order.
- Step mode: rx 53,4E with i_result_wb=0x12345678, i_tx_ready pulsed every 3rd cycle -> single o_step pulse. TX 12,34,56,78, each held until accepted. Returns to STEP_WAIT. Garbage byte 8'h00 ignored.
- Step to halt with dropped byte: rx 4E while i_finish=1 at sample, and an extra rx byte during SEND -> 4 result bytes then FF. Extra byte dropped. Ends in IDLE.
